// File: rtl/serial_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter_if
// Purpose  : Requester-side bus of the serial transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
) ();
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data;
    logic [NREQ-1:0]        gnt;
    logic [2:0]             owner;
    logic                   busy;
    logic                   done;
    logic                   txd;

    modport master (
        output req, data,
        input  gnt, owner, busy, done, txd
    );

    modport slave (
        input  req, data,
        output gnt, owner, busy, done, txd
    );
endinterface
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin arbiter that serialises the winning requester's byte
//            onto one shared txd line (start, LSB-first data, stop).
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [2:0]       c_OWN_LAST = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [DATA_W-1:0]   r_sr, w_sr_nxt;
    logic [2:0]          r_ptr, w_ptr_nxt;
    logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
    logic [2:0]          r_owner, w_owner_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_txd, w_txd_nxt;

    logic [NREQ-1:0]     w_rot;
    logic                w_found;
    logic [2:0]          w_off;
    logic [3:0]          w_sum;
    logic [2:0]          w_win;
    logic [NREQ-1:0]     w_win_oh;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_bit_end;
    logic [IDX_W-1:0]    w_idx_inc;

    // Rotate requests so bit 0 is the pointer position; the first set bit is the winner.
    always_comb begin
        w_rot   = NREQ'({bus.req, bus.req} >> r_ptr);
        w_found = 1'b0;
        w_off   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = 3'(i);
            end
        end
        w_sum = 4'(r_ptr) + 4'(w_off);
        w_win = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : w_sum[2:0];
    end

    always_comb begin
        w_win_oh   = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 3'(i)) begin
                w_win_oh[i] = 1'b1;
                w_win_data  = bus.data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_bit_end = (r_cnt == c_CNT_LAST);
    assign w_idx_inc = r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sr_nxt    = r_sr;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_found) begin
                    w_sr_nxt    = w_win_data;
                    w_gnt_nxt   = w_win_oh;
                    w_owner_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                    w_txd_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_txd_nxt   = r_sr[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_IDX_LAST) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_txd_nxt = r_sr[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    // Pointer advances only here, so withdrawn requests never move it.
                    w_ptr_nxt   = (r_owner == c_OWN_LAST) ? 3'd0 : r_owner + 3'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_ptr   <= 3'd0;
            r_gnt   <= '0;
            r_owner <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sr    <= w_sr_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.txd   = r_txd;
endmodule
`default_nettype wire
